// File: rtl/uart_rx_ctrl.sv
// UART receive controller: receiver handshake sequencing, byte FIFO and a two-register I/O port.
// Optional registered interrupt output enabled by defining UART_RX_CTRL_IRQ_EN.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_done,
  output logic       fsel,
  input  logic       io_adr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       irq
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t         state_q, state_d;
  logic           done_q, done_d;
  logic           fsel_q, fsel_d;
  logic           en_q, en_d;
  logic           ovr_q, ovr_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [7:0]     mem_q [DEPTH];

  logic capture;
  logic nonempty;
  logic full;
  logic pop;
  logic push;
  logic ovr_set;
  logic ctrl_wr;
  logic ie_bit;
  logic unused_wdata;

  assign unused_wdata = ^io_wdata[6:2];

  assign nonempty = (cnt_q != '0);
  assign full     = (cnt_q == FULL_CNT);
  assign ctrl_wr  = io_wr & io_adr;

  // A read of an empty FIFO never pops, so an empty push+pop only pushes.
  assign pop     = io_rd & ~io_adr & nonempty;
  assign push    = capture & en_q & (~full | pop);
  assign ovr_set = capture & en_q & full & ~pop;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!rx_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fsel_d = fsel_q;
    en_d   = en_q;
    ovr_d  = ovr_q;
    if (ctrl_wr) begin
      fsel_d = io_wdata[0];
      en_d   = io_wdata[1];
      if (io_wdata[7]) begin
        ovr_d = 1'b0;
      end
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      fsel_q  <= 1'b0;
      en_q    <= 1'b0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      fsel_q  <= fsel_d;
      en_q    <= en_d;
      ovr_q   <= ovr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= rx_data;
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;

  always_comb begin
    ie_d  = ie_q;
    if (ctrl_wr) begin
      ie_d = io_wdata[2];
    end
    irq_d = ie_q & (nonempty | ovr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_bit = ie_q;
  assign irq    = irq_q;
`else
  assign ie_bit = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    if (io_adr) begin
      io_rdata = {2'b00, ie_bit, en_q, fsel_q, ovr_q, full, nonempty};
    end else if (nonempty) begin
      io_rdata = mem_q[rptr_q];
    end
  end

  assign rx_done = done_q;
  assign fsel    = fsel_q;

endmodule
